// File: rtl/hex_entry.sv
// Front-panel hex entry: assembles address/data from key pulses, issues handshaked stores
// and register-load strobes. Define HEX_ENTRY_REGLOAD_EN to enable the A/X/Y/SP/PC load keys.
module hex_entry (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] key_hex,
  input  logic        b_load,
  input  logic        b_storeinc,
  input  logic        b_dec,
  input  logic        b_toA,
  input  logic        b_toX,
  input  logic        b_toY,
  input  logic        b_toSP,
  input  logic        b_toPC,
  output logic [15:0] addr,
  output logic [7:0]  data,
  output logic        mode,
  output logic        wr_req,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  input  logic        wr_ack,
  output logic [4:0]  reg_we,
  output logic [15:0] reg_wdata,
  output logic        busy
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t     state, next_state;
  logic       act_store, act_dec, act_load, act_hex;
  logic [3:0] hex_digit;

`ifdef HEX_ENTRY_REGLOAD_EN
  logic [4:0] to_keys;
  logic [4:0] to_sel;
  logic       act_reg;

  // Lowest set bit is the highest-priority register key (A first).
  assign to_keys = {b_toPC, b_toSP, b_toY, b_toX, b_toA};
  assign to_sel  = to_keys & (~to_keys + 5'd1);
`else
  logic unused_to_keys;

  assign unused_to_keys = &{1'b0, b_toA, b_toX, b_toY, b_toSP, b_toPC};
  assign reg_we    = 5'd0;
  assign reg_wdata = 16'd0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (act_store && mode) next_state = WRITE;
      WRITE:   if (wr_ack)            next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Key decode: only the highest-priority key acts, and only while idle and enabled.
  always_comb begin
    act_store = 1'b0;
    act_dec   = 1'b0;
    act_load  = 1'b0;
    act_hex   = 1'b0;
`ifdef HEX_ENTRY_REGLOAD_EN
    act_reg   = 1'b0;
`endif
    hex_digit = 4'd0;
    busy      = wr_req;
    for (int i = 15; i >= 0; i--) begin
      if (key_hex[i]) hex_digit = 4'(i);
    end
    if (state == IDLE && enable) begin
      if (b_storeinc)  act_store = 1'b1;
      else if (b_dec)  act_dec   = 1'b1;
      else if (b_load) act_load  = 1'b1;
`ifdef HEX_ENTRY_REGLOAD_EN
      else if (|to_keys) act_reg = 1'b1;
`endif
      else if (|key_hex) act_hex = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr    <= 16'h0000;
      data    <= 8'h00;
      mode    <= 1'b0;
      wr_req  <= 1'b0;
      wr_addr <= 16'h0000;
      wr_data <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (act_store) begin
            if (mode) begin
              wr_req  <= 1'b1;
              wr_addr <= addr;
              wr_data <= data;
            end else begin
              addr <= addr + 16'd1;
            end
          end else if (act_dec) begin
            addr <= addr - 16'd1;
          end else if (act_load) begin
            mode <= ~mode;
          end else if (act_hex) begin
            if (mode) data <= {data[3:0], hex_digit};
            else      addr <= {addr[11:0], hex_digit};
          end
        end
        WRITE: begin
          if (wr_ack) begin
            wr_req <= 1'b0;
            addr   <= addr + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef HEX_ENTRY_REGLOAD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_we    <= 5'd0;
      reg_wdata <= 16'd0;
    end else if (act_reg) begin
      reg_we    <= to_sel;
      reg_wdata <= to_sel[4] ? addr : {8'h00, data};
    end else begin
      reg_we    <= 5'd0;
      reg_wdata <= 16'd0;
    end
  end
`endif

endmodule

// File: doc/hex_entry.md
# hex_entry

Front-panel value assembler sitting directly downstream of the `keyboard` scanner and upstream of the panel bus-write path and the `cpu_control` register-load path. It consumes single-cycle key pulses and accumulates hex digits into a 16-bit address and an 8-bit data value. It issues handshaked memory store requests with address auto-increment, and one-cycle register-load strobes for A/X/Y/SP/PC.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  CLK25MHZ system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  panel entry permitted; high while the CPU is stopped
- `key_hex`  in  16  hex digit pulses; bit n = digit n
- `b_load`  in  1  toggles the entry mode
- `b_storeinc`  in  1  store and increment
- `b_dec`  in  1  decrement address
- `b_toA`, `b_toX`, `b_toY`, `b_toSP`, `b_toPC`  in  1 each  register-load keys
- `addr`  out  16  current entry address
- `data`  out  8  current entry data
- `mode`  out  1  0 = ADDR entry, 1 = DATA entry
- `wr_req`  out  1  memory write request
- `wr_addr`  out  16  write address
- `wr_data`  out  8  write data
- `wr_ack`  in  1  write done
- `reg_we`  out  5  one-hot register strobe, bits {PC,SP,Y,X,A} = [4:0]
- `reg_wdata`  out  16  register value
- `busy`  out  1  write in progress

## Operation
- All key inputs are one-`clk`-wide pulses from `keyboard`, already debounced and synchronous to `clk`.
- FSM states:
  - IDLE: keys are accepted only when `enable` = 1.
  - WRITE: all keys are ignored and `enable` is ignored; an accepted write always completes.
- Key priority when several pulse in the same cycle: `b_storeinc` > `b_dec` > `b_load` > to-keys (A > X > Y > SP > PC) > hex. Only the highest-priority key acts; the rest are dropped.
- Multiple `key_hex` bits set at once: lowest index wins.
- Hex digit d:
  - ADDR mode: `addr` <= {`addr`[11:0], d}.
  - DATA mode: `data` <= {`data`[3:0], d}.
- `b_load`: `mode` <= ~`mode`; `addr` and `data` are unchanged.
- `b_dec`: `addr` <= `addr` − 1, mod 2^16 (0x0000 → 0xFFFF).
- `b_storeinc` in ADDR mode: `addr` <= `addr` + 1, mod 2^16; no write is issued.
- `b_storeinc` in DATA mode: capture `wr_addr` <= `addr`, `wr_data` <= `data`; set `wr_req` = 1; go to WRITE.
- WRITE:
  - Hold `wr_req`, `wr_addr` and `wr_data` stable until `wr_ack` is sampled high.
  - On that edge: `wr_req` <= 0, `addr` <= `addr` + 1 (0xFFFF → 0x0000), return to IDLE.
  - `data` is retained so the same byte can be stored repeatedly.
- `wr_ack` is ignored in IDLE.
- `busy` = `wr_req`.
- To-keys:
  - One-cycle pulse on the matching `reg_we` bit.
  - `reg_wdata` = {8'h00, `data`} for A/X/Y/SP; `addr` for PC.
  - `reg_wdata` is valid only in the cycle its strobe is high; 0 otherwise.
- Reset values: `addr` = 0x0000, `data` = 0x00, `mode` = 0, `wr_req` = 0, `wr_addr` = 0x0000, `wr_data` = 0x00, `reg_we` = 0, `reg_wdata` = 0, `busy` = 0; FSM = IDLE.
- Reset asserted mid-WRITE drops the request immediately, with no increment.

## Timing
- A key pulse sampled at edge N updates `addr`/`data`/`mode` by edge N; the new value is visible in cycle N+1.
- `b_storeinc` at edge N: `wr_req`, `wr_addr` and `wr_data` are valid after N.
- `wr_ack` sampled high at edge M: `wr_req` is low and `addr` is incremented after M.
- Minimum write occupancy is 1 cycle: `wr_ack` already high at edge N+1 completes the write there.
- `reg_we` is high for exactly the cycle after the key edge; it never stays high two cycles for one pulse.
- Back-to-back accepted keys in consecutive cycles in IDLE are each honoured.

## Configuration
- `HEX_ENTRY_REGLOAD_EN` defined: to-keys act as described.
- Undefined:
  - `reg_we` and `reg_wdata` are tied to 0.
  - To-keys are ignored and do not block lower-priority keys in the same cycle.
  - All ports remain present.

## Test plan
- Reset, `enable` = 1, pulse hex 1,2,3,4 in ADDR mode -> `addr` = 0x1234, `data` = 0x00, `mode` = 0.
- `b_load`, hex A,5, `b_storeinc`, hold `wr_ack` low 3 cycles then high 1 cycle -> `wr_req` high exactly 4 cycles with `wr_addr` = 0x1234 and `wr_data` = 0xA5; afterwards `addr` = 0x1235, `data` = 0xA5.
- `addr` = 0xFFFF, DATA-mode store with immediate ack -> write to 0xFFFF, then `addr` = 0x0000. Then `b_dec` -> `addr` = 0xFFFF.
- Same-cycle `b_dec` + hex 7 at `addr` = 0x0010 -> `addr` = 0x000F only. Key pulses during WRITE or with `enable` = 0 -> no state change.
- With macro defined, `data` = 0x3C, pulse `b_toX` -> `reg_we` = 5'b00010 for one cycle with `reg_wdata` = 0x003C. `b_toPC` at `addr` = 0xC000 -> `reg_we` = 5'b10000, `reg_wdata` = 0xC000. Without macro -> `reg_we` stays 0.
- Assert `rst_n` low mid-WRITE -> `wr_req` drops asynchronously; all outputs at reset values; after release, a late `wr_ack` causes no change.
